// File: rtl/oct_disp_pkg.sv
// Shared types and helpers for the octal seven-segment scan readout.
// Latency: n/a (pure declarations and combinational helper functions).
// Backpressure: n/a.
package oct_disp_pkg;

    localparam int NUM_DIGITS = 3;
    localparam int DIGIT_W    = 3;

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } scan_state_t;

    typedef logic [1:0] dig_idx_t;

    // Octal digit idx of an 8-bit value; the top digit only has two real bits.
    function automatic logic [DIGIT_W-1:0] digit_of(input logic [7:0] val, input dig_idx_t idx);
        case (idx)
            2'd0:    digit_of = val[2:0];
            2'd1:    digit_of = val[5:3];
            default: digit_of = {1'b0, val[7:6]};
        endcase
    endfunction

    // 1 when the digit slot should be lit. The least significant digit always
    // shows, so a zero value still reads "0".
    function automatic logic digit_lit(input logic [7:0] val, input dig_idx_t idx,
                                       input logic blank_lz);
        case (idx)
            2'd0:    digit_lit = 1'b1;
            2'd1:    digit_lit = !blank_lz || (val[7:3] != 5'd0);
            default: digit_lit = !blank_lz || (val[7:6] != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/oct_scan_ctrl_if.sv
// Value handshake and digit-drive bundle between the ALU side and the scanner.
// Latency: n/a (wires only).
// Backpressure: ready low means load is ignored; no other flow control.
//   load/value/ready : result hand-off (load sampled only while ready=1)
//   clear/blank_lz   : blank-and-flush request, leading-zero suppression select
//   oct_digit/dig_en : digit code to the shared decoder, one-hot digit enable
interface oct_scan_ctrl_if;
    import oct_disp_pkg::*;

    logic                  load;
    logic [7:0]            value;
    logic                  ready;
    logic                  clear;
    logic                  blank_lz;
    logic [DIGIT_W-1:0]    oct_digit;
    logic [NUM_DIGITS-1:0] dig_en;

    modport master (
        output load, value, clear, blank_lz,
        input  ready, oct_digit, dig_en
    );

    modport slave (
        input  load, value, clear, blank_lz,
        output ready, oct_digit, dig_en
    );

endinterface

// File: rtl/oct_refresh_timer.sv
// Digit-slot prescaler: one-cycle tick every REFRESH_DIV clocks.
// Latency: tick is high during the last cycle of each slot (cnt = REFRESH_DIV-1).
// Backpressure: none; sclr holds the count at zero.
//   clk, rst_n : clock, async active-low reset
//   sclr       : synchronous clear to count 0
//   tick       : terminal-count strobe
module oct_refresh_timer #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclr,
    output logic tick
);

    localparam int               CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sclr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/oct_scan_ctrl.sv
// 3-digit octal scan controller with frame-aligned double buffering.
// Latency: first value shows 1 cycle after load; later values commit at the next frame end.
// Backpressure: ready drops while a value waits in the pending buffer.
//   clk, rst_n : clock, async active-low reset
//   bus        : load/value/ready handshake, clear, blank_lz, oct_digit/dig_en drive
module oct_scan_ctrl #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    oct_scan_ctrl_if.slave  bus
);
    import oct_disp_pkg::*;

    scan_state_t state, state_nxt;
    logic [7:0]  active, active_nxt;
    logic [7:0]  pending, pending_nxt;
    logic        pend, pend_nxt;
    dig_idx_t    idx, idx_nxt;
    logic        tick;
    logic        frame_end;
    logic        slot_edge;

    // Timer only runs while scanning, so entering SCAN always starts a full slot.
    oct_refresh_timer #(.REFRESH_DIV(REFRESH_DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .sclr  (bus.clear || (state == BLANK)),
        .tick  (tick)
    );

    // A value waits in the pending buffer exactly when the handshake is closed.
    assign bus.ready = !pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        active_nxt  = active;
        pending_nxt = pending;
        pend_nxt    = pend;
        idx_nxt     = idx;
        slot_edge   = 1'b0;
        frame_end   = tick && (idx == 2'd2);

        if (bus.clear) begin
            state_nxt = BLANK;
            pend_nxt  = 1'b0;
            idx_nxt   = 2'd0;
        end else begin
            case (state)
                BLANK: begin
                    if (bus.load) begin
                        state_nxt  = SCAN;
                        active_nxt = bus.value;
                        idx_nxt    = 2'd0;
                        slot_edge  = 1'b1;
                    end
                end
                SCAN: begin
                    if (tick) begin
                        slot_edge = 1'b1;
                        idx_nxt   = frame_end ? 2'd0 : idx + 2'd1;
                    end
                    if (frame_end && pend) begin
                        active_nxt = pending;
                        pend_nxt   = 1'b0;
                    end else if (bus.load && !pend) begin
                        // At the frame edge the new value can go straight on
                        // screen; elsewhere it must wait so a frame never mixes values.
                        if (frame_end) begin
                            active_nxt = bus.value;
                        end else begin
                            pending_nxt = bus.value;
                            pend_nxt    = 1'b1;
                        end
                    end
                end
                default: state_nxt = BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= '0;
            pending <= '0;
            pend    <= 1'b0;
            idx     <= 2'd0;
        end else begin
            active  <= active_nxt;
            pending <= pending_nxt;
            pend    <= pend_nxt;
            idx     <= idx_nxt;
        end
    end

    // Outputs are rebuilt only on slot edges, so blank_lz changes land on the
    // next slot and the drive is stable for the whole slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dig_en    <= '0;
            bus.oct_digit <= '0;
        end else if (state_nxt == BLANK) begin
            bus.dig_en    <= '0;
            bus.oct_digit <= '0;
        end else if (slot_edge) begin
            if (digit_lit(active_nxt, idx_nxt, bus.blank_lz)) begin
                bus.dig_en    <= NUM_DIGITS'(1) << idx_nxt;
                bus.oct_digit <= digit_of(active_nxt, idx_nxt);
            end else begin
                bus.dig_en    <= '0;
                bus.oct_digit <= '0;
            end
        end
    end

endmodule

// File: tb/tb_oct_scan_ctrl.sv
// Self-checking bench for oct_scan_ctrl with a cycle-count based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_oct_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 3 * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    oct_scan_ctrl_if bus();

    oct_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [6:0] obs;
    assign obs = {bus.ready, bus.dig_en, bus.oct_digit};

    // Reference model: display position is simply the number of cycles spent
    // scanning since the last start; slot = (cycles / DIV) mod 3.
    int         m_cyc   = 0;
    bit         m_blank = 1'b1;
    bit         m_pend  = 1'b0;
    bit         m_lz    = 1'b0;
    logic [7:0] m_shown = 8'h00;
    logic [7:0] m_pval  = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_blank = 1'b1; m_pend = 1'b0; m_cyc = 0;
            m_shown = 8'h00; m_pval = 8'h00; m_lz = 1'b0;
        end else if (bus.clear) begin
            m_blank = 1'b1; m_pend = 1'b0; m_cyc = 0;
        end else if (m_blank) begin
            if (bus.load) begin
                m_blank = 1'b0; m_shown = bus.value; m_cyc = 0; m_lz = bus.blank_lz;
            end
        end else begin
            if ((m_cyc % FRAME) == FRAME - 1) begin
                if (m_pend) begin
                    m_shown = m_pval; m_pend = 1'b0;
                end else if (bus.load) begin
                    m_shown = bus.value;
                end
            end else if (bus.load && !m_pend) begin
                m_pval = bus.value; m_pend = 1'b1;
            end
            m_cyc = m_cyc + 1;
            if ((m_cyc % DIV) == 0) m_lz = bus.blank_lz;
        end
    end

    // {ready, dig_en, oct_digit} the model predicts for the current cycle.
    function automatic logic [6:0] model_out();
        int slot;
        int d;
        logic [6:0] r;
        r = {~m_pend, 6'b0};
        if (!m_blank) begin
            slot = (m_cyc / DIV) % 3;
            d = (int'(m_shown) >> (3 * slot)) & 7;
            if (slot == 0 || !m_lz || int'(m_shown) >= (1 << (3 * slot)))
                r[5:0] = {3'(1 << slot), 3'(d)};
        end
        return r;
    endfunction

    task automatic test_reset();
        bus.load = 1'b0; bus.value = 8'h00; bus.clear = 1'b0; bus.blank_lz = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== 7'b1_000_000) begin
            fails++; $display("FAIL reset_state: got %b expected %b", obs, 7'b1_000_000);
        end
        bus.load = 1'b1; bus.value = 8'h5B;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (obs !== model_out()) begin
            fails++; $display("FAIL pre_reset_scan: got %b expected %b", obs, model_out());
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== 7'b1_000_000) begin
            fails++; $display("FAIL async_reset: got %b expected %b", obs, 7'b1_000_000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_scan();
        int s;
        logic [6:0] e;
        bus.load = 1'b1; bus.value = 8'hA5;
        @(negedge clk);
        bus.load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s = (i / DIV) % 3;
            e = {1'b1, 3'(1 << s), (s == 0) ? 3'd5 : (s == 1) ? 3'd4 : 3'd2};
            tests++;
            if (obs !== e) begin
                fails++; $display("FAIL basic_scan[%0d]: got %b expected %b", i, obs, e);
            end
            tests++;
            if (obs !== model_out()) begin
                fails++; $display("FAIL basic_scan_model[%0d]: got %b expected %b", i, obs, model_out());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_frame_update();
        int n;
        logic [6:0] e;
        n = 0;
        while (bus.dig_en !== 3'b010 && n < 2 * FRAME) begin @(negedge clk); n++; end
        tests++;
        if (bus.dig_en !== 3'b010) begin
            fails++; $display("FAIL mid_align: got %b expected %b", bus.dig_en, 3'b010);
        end
        bus.load = 1'b1; bus.value = 8'h07;
        @(negedge clk);
        bus.load = 1'b0;
        for (int j = 0; j < 19; j++) begin
            if (j == 1) begin bus.load = 1'b1; bus.value = 8'hFF; end
            else bus.load = 1'b0;
            if (j < 3)       e = 7'b0_010_100;
            else if (j < 7)  e = 7'b0_100_010;
            else if (j < 11) e = 7'b1_001_111;
            else if (j < 15) e = 7'b1_010_000;
            else             e = 7'b1_100_000;
            tests++;
            if (obs !== e) begin
                fails++; $display("FAIL mid_frame[%0d]: got %b expected %b", j, obs, e);
            end
            tests++;
            if (obs !== model_out()) begin
                fails++; $display("FAIL mid_frame_model[%0d]: got %b expected %b", j, obs, model_out());
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
    endtask

    task automatic test_boundary_load();
        int n;
        n = 0;
        while (bus.dig_en === 3'b100 && n < 2 * FRAME) begin @(negedge clk); n++; end
        while (bus.dig_en !== 3'b100 && n < 2 * FRAME) begin @(negedge clk); n++; end
        tests++;
        if (bus.dig_en !== 3'b100) begin
            fails++; $display("FAIL bound_align: got %b expected %b", bus.dig_en, 3'b100);
        end
        repeat (DIV - 1) @(negedge clk);
        bus.load = 1'b1; bus.value = 8'h3F;
        tests++;
        if (obs !== 7'b1_100_000) begin
            fails++; $display("FAIL bound_pre: got %b expected %b", obs, 7'b1_100_000);
        end
        @(negedge clk);
        bus.load = 1'b0;
        tests++;
        if (obs !== 7'b1_001_111) begin
            fails++; $display("FAIL bound_commit: got %b expected %b", obs, 7'b1_001_111);
        end
        for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            tests++;
            if (bus.ready !== 1'b1 || obs !== model_out()) begin
                fails++; $display("FAIL bound_after[%0d]: got %b expected %b", k, obs, model_out());
            end
        end
    endtask

    task automatic test_leading_zeros();
        logic [7:0]  val;
        logic [17:0] row;
        int s;
        logic [6:0] e;
        bus.blank_lz = 1'b1;
        for (int v = 0; v < 3; v++) begin
            case (v)
                0:       begin val = 8'h07; row = 18'b001111_000000_000000; end
                1:       begin val = 8'h00; row = 18'b001000_000000_000000; end
                default: begin val = 8'h40; row = 18'b001000_010000_100001; end
            endcase
            bus.clear = 1'b1;
            @(negedge clk);
            bus.clear = 1'b0; bus.load = 1'b1; bus.value = val;
            @(negedge clk);
            bus.load = 1'b0;
            for (int i = 0; i < FRAME; i++) begin
                s = i / DIV;
                e = {1'b1, row[17 - 6 * s -: 6]};
                tests++;
                if (obs !== e) begin
                    fails++; $display("FAIL lz_%h[%0d]: got %b expected %b", val, i, obs, e);
                end
                tests++;
                if (obs !== model_out()) begin
                    fails++; $display("FAIL lz_model_%h[%0d]: got %b expected %b", val, i, obs, model_out());
                end
                @(negedge clk);
            end
        end
        bus.blank_lz = 1'b0;
    endtask

    task automatic test_clear();
        int n;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0; bus.load = 1'b1; bus.value = 8'hA5;
        @(negedge clk);
        bus.load = 1'b0;
        n = 0;
        while (bus.dig_en !== 3'b010 && n < 2 * FRAME) begin @(negedge clk); n++; end
        bus.load = 1'b1; bus.value = 8'h3C;
        @(negedge clk);
        bus.load = 1'b0;
        tests++;
        if (bus.ready !== 1'b0) begin
            fails++; $display("FAIL clear_pend_ready: got %b expected %b", bus.ready, 1'b0);
        end
        bus.clear = 1'b1; bus.load = 1'b1; bus.value = 8'h11;
        @(negedge clk);
        bus.clear = 1'b0; bus.load = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tests++;
            if (obs !== 7'b1_000_000 || obs !== model_out()) begin
                fails++; $display("FAIL clear_blank[%0d]: got %b expected %b", i, obs, 7'b1_000_000);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        for (int i = 0; i < 3000; i++) begin
            tests++;
            if (obs !== model_out()) begin
                fails++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random[%0d]: got %b expected %b", i, obs, model_out());
                end
            end
            bus.clear = ($urandom_range(0, 63) == 0);
            bus.load  = ($urandom_range(0, 3) == 0);
            bus.value = 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
            @(negedge clk);
        end
        bus.load = 1'b0; bus.clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_mid_frame_update();
        test_boundary_load();
        test_leading_zeros();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
